// File: rtl/algo_2ru_cntr_upd.sv
// Two-port counter-update engine: each port reads a word from the 2ru memory,
// adds an unsigned delta with saturation and writes the result back.
module algo_2ru_cntr_upd #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int BITDLTA = 8,
  parameter int TIMEOUT = 16,
  parameter int BITTOUT = 5,
  parameter int NUMRUPT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ready,
  input  logic [NUMRUPT-1:0]           upd_vld,
  output logic [NUMRUPT-1:0]           upd_rdy,
  input  logic [NUMRUPT*BITADDR-1:0]   upd_addr,
  input  logic [NUMRUPT*BITDLTA-1:0]   upd_delta,
  output logic [NUMRUPT-1:0]           ru_read,
  output logic [NUMRUPT-1:0]           ru_write,
  output logic [NUMRUPT*BITADDR-1:0]   ru_addr,
  output logic [NUMRUPT*WIDTH-1:0]     ru_din,
  input  logic [NUMRUPT-1:0]           ru_vld,
  input  logic [NUMRUPT*WIDTH-1:0]     ru_dout,
  input  logic [NUMRUPT-1:0]           ru_serr,
  input  logic [NUMRUPT-1:0]           ru_derr,
  output logic [NUMRUPT-1:0]           done,
  output logic [NUMRUPT-1:0]           done_err,
  output logic [NUMRUPT*WIDTH-1:0]     done_val,
  output logic [NUMRUPT*8-1:0]         serr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  localparam logic [BITTOUT-1:0] TLAST = BITTOUT'(TIMEOUT - 1);
  localparam logic [BITTOUT-1:0] TONE  = {{(BITTOUT-1){1'b0}}, 1'b1};

  state_t               r_state     [NUMRUPT];
  state_t               w_state_nxt [NUMRUPT];
  logic [BITTOUT-1:0]   r_timer     [NUMRUPT];
  logic [BITTOUT-1:0]   w_timer_nxt [NUMRUPT];
  logic [BITDLTA-1:0]   r_delta     [NUMRUPT];
  logic [BITDLTA-1:0]   w_delta_nxt [NUMRUPT];
  logic [WIDTH:0]       w_sum       [NUMRUPT];
  logic [WIDTH-1:0]     w_sat       [NUMRUPT];

  logic [NUMRUPT-1:0]         w_upd_rdy;
  logic [NUMRUPT-1:0]         r_ru_read,  w_ru_read_nxt;
  logic [NUMRUPT-1:0]         r_ru_write, w_ru_write_nxt;
  logic [NUMRUPT-1:0]         r_done,     w_done_nxt;
  logic [NUMRUPT-1:0]         r_done_err, w_done_err_nxt;
  logic [NUMRUPT*BITADDR-1:0] r_ru_addr,  w_ru_addr_nxt;
  logic [NUMRUPT*WIDTH-1:0]   r_ru_din,   w_ru_din_nxt;
  logic [NUMRUPT*WIDTH-1:0]   r_done_val, w_done_val_nxt;
  logic [NUMRUPT*8-1:0]       r_serr_cnt, w_serr_cnt_nxt;

  always_comb begin
    w_upd_rdy = '0;
    for (int p = 0; p < NUMRUPT; p++) begin
      w_upd_rdy[p] = ready && (r_state[p] == S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_delta_nxt    = r_delta;
    w_ru_read_nxt  = '0;
    w_ru_write_nxt = '0;
    w_done_nxt     = '0;
    w_done_err_nxt = '0;
    w_ru_addr_nxt  = r_ru_addr;
    w_ru_din_nxt   = r_ru_din;
    w_done_val_nxt = r_done_val;
    w_serr_cnt_nxt = r_serr_cnt;
    for (int p = 0; p < NUMRUPT; p++) begin
      // one spare bit catches the carry that triggers saturation
      w_sum[p] = {1'b0, ru_dout[p*WIDTH +: WIDTH]} +
                 {{(WIDTH+1-BITDLTA){1'b0}}, r_delta[p]};
      w_sat[p] = w_sum[p][WIDTH] ? {WIDTH{1'b1}} : w_sum[p][WIDTH-1:0];
      case (r_state[p])
        S_IDLE: begin
          if (upd_vld[p] && w_upd_rdy[p]) begin
            w_state_nxt[p]                     = S_RD;
            w_ru_read_nxt[p]                   = 1'b1;
            w_ru_addr_nxt[p*BITADDR +: BITADDR] = upd_addr[p*BITADDR +: BITADDR];
            w_delta_nxt[p]                     = upd_delta[p*BITDLTA +: BITDLTA];
          end else begin
            w_state_nxt[p] = S_IDLE;
          end
        end
        S_RD: begin
          w_state_nxt[p] = S_WAIT;
          w_timer_nxt[p] = {BITTOUT{1'b0}};
        end
        S_WAIT: begin
          w_timer_nxt[p] = r_timer[p] + TONE;
          if (ru_vld[p]) begin
            if (ru_serr[p] && (r_serr_cnt[p*8 +: 8] != 8'hFF)) begin
              w_serr_cnt_nxt[p*8 +: 8] = r_serr_cnt[p*8 +: 8] + 8'd1;
            end else begin
              w_serr_cnt_nxt[p*8 +: 8] = r_serr_cnt[p*8 +: 8];
            end
            if (ru_derr[p]) begin
              w_state_nxt[p]                 = S_IDLE;
              w_done_nxt[p]                  = 1'b1;
              w_done_err_nxt[p]              = 1'b1;
              w_done_val_nxt[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else begin
              w_state_nxt[p]                 = S_WR;
              w_ru_write_nxt[p]              = 1'b1;
              w_done_nxt[p]                  = 1'b1;
              w_ru_din_nxt[p*WIDTH +: WIDTH]   = w_sat[p];
              w_done_val_nxt[p*WIDTH +: WIDTH] = w_sat[p];
            end
          end else if (r_timer[p] == TLAST) begin
            w_state_nxt[p]                 = S_IDLE;
            w_done_nxt[p]                  = 1'b1;
            w_done_err_nxt[p]              = 1'b1;
            w_done_val_nxt[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
          end else begin
            w_state_nxt[p] = S_WAIT;
          end
        end
        S_WR: begin
          w_state_nxt[p] = S_IDLE;
        end
        default: begin
          w_state_nxt[p] = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUMRUPT; p++) begin
        r_state[p] <= S_IDLE;
        r_timer[p] <= {BITTOUT{1'b0}};
        r_delta[p] <= {BITDLTA{1'b0}};
      end
      r_ru_read  <= '0;
      r_ru_write <= '0;
      r_done     <= '0;
      r_done_err <= '0;
      r_ru_addr  <= '0;
      r_ru_din   <= '0;
      r_done_val <= '0;
      r_serr_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_delta    <= w_delta_nxt;
      r_ru_read  <= w_ru_read_nxt;
      r_ru_write <= w_ru_write_nxt;
      r_done     <= w_done_nxt;
      r_done_err <= w_done_err_nxt;
      r_ru_addr  <= w_ru_addr_nxt;
      r_ru_din   <= w_ru_din_nxt;
      r_done_val <= w_done_val_nxt;
      r_serr_cnt <= w_serr_cnt_nxt;
    end
  end

  assign upd_rdy  = w_upd_rdy;
  assign ru_read  = r_ru_read;
  assign ru_write = r_ru_write;
  assign ru_addr  = r_ru_addr;
  assign ru_din   = r_ru_din;
  assign done     = r_done;
  assign done_err = r_done_err;
  assign done_val = r_done_val;
  assign serr_cnt = r_serr_cnt;

endmodule

// File: tb/tb_algo_2ru_cntr_upd.sv
// Randomized bench for algo_2ru_cntr_upd: the bench plays the memory and predicts
// every strobe cycle and value from per-transaction timing rules.
module tb_algo_2ru_cntr_upd;
  localparam int WIDTH = 32, BITADDR = 13, BITDLTA = 8, TIMEOUT = 16, BITTOUT = 5;

  logic clk = 1'b0;
  logic rst, ready;
  logic [1:0] upd_vld, upd_rdy, ru_read, ru_write, ru_vld, ru_serr, ru_derr, done, done_err;
  logic [2*BITADDR-1:0] upd_addr, ru_addr;
  logic [2*BITDLTA-1:0] upd_delta;
  logic [2*WIDTH-1:0] ru_din, ru_dout, done_val;
  logic [15:0] serr_cnt;

  always #5 clk = ~clk;

  algo_2ru_cntr_upd #(.WIDTH(WIDTH), .BITADDR(BITADDR), .BITDLTA(BITDLTA),
                      .TIMEOUT(TIMEOUT), .BITTOUT(BITTOUT), .NUMRUPT(2)) u_dut (
    .clk(clk), .rst(rst), .ready(ready), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
    .upd_addr(upd_addr), .upd_delta(upd_delta), .ru_read(ru_read), .ru_write(ru_write),
    .ru_addr(ru_addr), .ru_din(ru_din), .ru_vld(ru_vld), .ru_dout(ru_dout),
    .ru_serr(ru_serr), .ru_derr(ru_derr), .done(done), .done_err(done_err),
    .done_val(done_val), .serr_cnt(serr_cnt)
  );

  // mode: 0 = good read, 1 = uncorrectable error, 2 = no response (timeout)
  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  delta;
    logic [2:0]  lat;
    logic [1:0]  mode;
    logic        serr;
  } txn_t;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_serr0 = 0;
  bit gen_on = 1'b0, serr_phase = 1'b0, rand_ready = 1'b0, ready_hold = 1'b0;
  logic [31:0] mem [2][16];
  txn_t dq0[$], dq1[$];
  txn_t req [2], act [2];
  bit   busy [2], req_on [2], exp_rdy [2];
  int   acc_t [2], resp_t [2], done_t [2], free_t [2], late_t [2], next_req_t [2];
  int   exp_serr [2];
  logic [31:0] exp_val [2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(logic [31:0] a, logic [7:0] d);
    logic [63:0] s;
    s = 64'(a) + 64'(d);
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic txn_t gen_txn(int p);
    txn_t x;
    int r;
    x.addr  = 13'($urandom_range(0, 15));
    x.delta = 8'($urandom);
    x.lat   = 3'($urandom_range(1, 5));
    r = $urandom_range(0, 9);
    x.mode  = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
    x.serr  = ($urandom_range(0, 3) == 0);
    if (serr_phase) begin
      if (p == 0) begin
        x.mode = 2'd0; x.lat = 3'd1; x.serr = 1'b1;
      end else begin
        x.serr = 1'b0;
      end
    end
    return x;
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; req_on[p] = 1'b0; exp_serr[p] = 0;
      late_t[p] = -1; resp_t[p] = -1; done_t[p] = -1; free_t[p] = -1;
      acc_t[p] = -10; next_req_t[p] = 0;
    end
  endtask

  // Inputs seen by the DUT during cycle cyc.
  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      ru_vld[p] = 1'b0; ru_serr[p] = 1'b0; ru_derr[p] = 1'b0;
      ru_dout[p*WIDTH +: WIDTH] = $urandom;
      if (busy[p] && act[p].mode != 2'd2 && cyc == resp_t[p]) begin
        ru_vld[p]  = 1'b1;
        ru_dout[p*WIDTH +: WIDTH] = mem[p][act[p].addr[3:0]];
        ru_serr[p] = act[p].serr;
        ru_derr[p] = (act[p].mode == 2'd1);
      end else if (cyc == late_t[p]) begin
        ru_vld[p]  = 1'b1;
        ru_serr[p] = 1'b1;
        ru_derr[p] = 1'($urandom_range(0, 1));
      end
      if (!req_on[p] && cyc >= next_req_t[p]) begin
        if (p == 0 && dq0.size() > 0) begin
          req[p] = dq0.pop_front(); req_on[p] = 1'b1;
        end else if (p == 1 && dq1.size() > 0) begin
          req[p] = dq1.pop_front(); req_on[p] = 1'b1;
        end else if (gen_on) begin
          req[p] = gen_txn(p); req_on[p] = 1'b1;
        end
      end
      upd_vld[p] = req_on[p];
      upd_addr[p*BITADDR +: BITADDR]  = req[p].addr;
      upd_delta[p*BITDLTA +: BITDLTA] = req[p].delta;
    end
    ready = rand_ready ? ($urandom_range(0, 7) != 0) : ready_hold;
  endtask

  // Compare every output of cycle cyc against the transaction timeline.
  task automatic check_cycle();
    bit e_rd, e_wr, e_dn, e_er;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      exp_rdy[p] = ready && !(busy[p] && cyc < free_t[p]);
      e_rd = busy[p] && (cyc == acc_t[p] + 1);
      e_dn = busy[p] && (cyc == done_t[p]);
      e_er = e_dn && (act[p].mode != 2'd0);
      e_wr = e_dn && (act[p].mode == 2'd0);
      chk($sformatf("p%0d_upd_rdy", p), 64'(upd_rdy[p]), 64'(exp_rdy[p]));
      chk($sformatf("p%0d_ru_read", p), 64'(ru_read[p]), 64'(e_rd));
      chk($sformatf("p%0d_ru_write", p), 64'(ru_write[p]), 64'(e_wr));
      chk($sformatf("p%0d_done", p), 64'(done[p]), 64'(e_dn));
      chk($sformatf("p%0d_done_err", p), 64'(done_err[p]), 64'(e_er));
      chk($sformatf("p%0d_serr_cnt", p), 64'(serr_cnt[p*8 +: 8]), 64'(exp_serr[p]));
      if (e_rd) chk($sformatf("p%0d_rd_addr", p), 64'(ru_addr[p*BITADDR +: BITADDR]), 64'(act[p].addr));
      if (e_wr) begin
        chk($sformatf("p%0d_wr_addr", p), 64'(ru_addr[p*BITADDR +: BITADDR]), 64'(act[p].addr));
        chk($sformatf("p%0d_ru_din", p), 64'(ru_din[p*WIDTH +: WIDTH]), 64'(exp_val[p]));
        mem[p][act[p].addr[3:0]] = exp_val[p];
      end
      if (e_dn) chk($sformatf("p%0d_done_val", p), 64'(done_val[p*WIDTH +: WIDTH]),
                    e_er ? 64'd0 : 64'(exp_val[p]));
      if (busy[p] && cyc >= done_t[p]) busy[p] = 1'b0;
    end
  endtask

  // Clock edge: account for accepted requests and counted single-bit errors.
  task automatic advance();
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (busy[p] && act[p].mode != 2'd2 && cyc == resp_t[p] && act[p].serr) begin
        if (exp_serr[p] < 255) exp_serr[p]++;
        if (p == 0) n_serr0++;
      end
      if (req_on[p] && exp_rdy[p]) begin
        act[p] = req[p]; busy[p] = 1'b1; req_on[p] = 1'b0; acc_t[p] = cyc;
        resp_t[p]  = cyc + 1 + int'(act[p].lat);
        exp_val[p] = sat_add(mem[p][act[p].addr[3:0]], act[p].delta);
        case (act[p].mode)
          2'd0: begin done_t[p] = resp_t[p] + 1; free_t[p] = done_t[p] + 1; end
          2'd1: begin done_t[p] = resp_t[p] + 1; free_t[p] = done_t[p]; end
          default: begin
            resp_t[p] = -1; done_t[p] = cyc + 2 + TIMEOUT;
            free_t[p] = done_t[p]; late_t[p] = done_t[p];
          end
        endcase
        next_req_t[p] = cyc + 1 + (serr_phase ? 0 : int'($urandom_range(0, 3)));
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    check_cycle();
    advance();
    drive();
  endtask

  initial begin
    int n;
    rst = 1'b1; ready = 1'b0; upd_vld = '0; upd_addr = '0; upd_delta = '0;
    ru_vld = '0; ru_dout = '0; ru_serr = '0; ru_derr = '0;
    clear_model();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        mem[p][i] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom);
    mem[0][5] = 32'd10;
    mem[1][7] = 32'hFFFF_FFFE;
    dq0.push_back('{addr: 13'h005, delta: 8'd3, lat: 3'd1, mode: 2'd0, serr: 1'b0});
    dq0.push_back('{addr: 13'h002, delta: 8'd1, lat: 3'd2, mode: 2'd1, serr: 1'b0});
    dq1.push_back('{addr: 13'h007, delta: 8'd5, lat: 3'd1, mode: 2'd0, serr: 1'b0});
    dq1.push_back('{addr: 13'h003, delta: 8'd9, lat: 3'd1, mode: 2'd2, serr: 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {ru_read, ru_write, done, done_err, serr_cnt}, 64'd0);
    chk("rst_addr", 64'(ru_addr), 64'd0);
    chk("rst_din_val", 64'(ru_din | done_val), 64'd0);
    chk("rst_upd_rdy", 64'(upd_rdy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_hold = 1'b1;
    drive();

    // Directed transactions first, then random traffic with ready toggling.
    repeat (60) step();
    gen_on = 1'b1; rand_ready = 1'b1;
    repeat (1500) step();

    // Drain, then reset while port 0 sits in WAIT.
    gen_on = 1'b0; rand_ready = 1'b0; ready_hold = 1'b1;
    n = 0;
    while ((busy[0] || busy[1] || req_on[0] || req_on[1]) && n < 300) begin step(); n++; end
    if (n >= 300) chk("drain_budget", 64'd0, 64'd1);
    dq0.push_back('{addr: 13'h009, delta: 8'd1, lat: 3'd1, mode: 2'd2, serr: 1'b0});
    n = 0;
    do begin step(); n++; end while (!(busy[0] && cyc >= acc_t[0] + 4) && n < 100);
    if (n >= 100) chk("wait_budget", 64'd0, 64'd1);
    rst = 1'b1; ready = 1'b0; upd_vld = '0; ru_vld = '0;
    @(posedge clk);
    #1;
    clear_model();
    cyc++;
    rst = 1'b0; ready_hold = 1'b0;
    late_t[0] = cyc;
    drive();
    check_cycle();
    chk("post_rst_addr", 64'(ru_addr), 64'd0);
    chk("post_rst_din", 64'(ru_din), 64'd0);
    chk("post_rst_done_val", 64'(done_val), 64'd0);
    advance();
    dq0.push_back('{addr: 13'h004, delta: 8'd2, lat: 3'd2, mode: 2'd0, serr: 1'b1});
    drive();
    repeat (5) step();
    chk("rdy_blocked", 64'(upd_rdy), 64'd0);
    ready_hold = 1'b1;
    repeat (20) step();

    // Saturate port 0 single-bit error counter.
    serr_phase = 1'b1; gen_on = 1'b1; n_serr0 = 0;
    n = 0;
    while (n_serr0 < 300 && n < 4000) begin step(); n++; end
    if (n >= 4000) chk("serr_budget", 64'd0, 64'd1);
    gen_on = 1'b0;
    repeat (40) step();
    chk("serr0_sat", 64'(serr_cnt[7:0]), 64'd255);
    chk("serr1_zero", 64'(serr_cnt[15:8]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
